// File: rtl/country_road_car_detector.sv
// Country-road vehicle detector: synchronises and debounces the loop sensor,
// keeps a saturating count of queued cars and drains it during country green.
module country_road_car_detector #(
  parameter int DEBOUNCE    = 4,
  parameter int PASS_CYCLES = 8,
  parameter int MAX_CARS    = 7
) (
  input  logic                              CLOCK,
  input  logic                              CLEAR,
  input  logic                              SENSOR_RAW,
  input  logic [1:0]                        COUNTRY_SIG,
  output logic                              CAR_ON_COUNTRY_ROAD,
  output logic [$clog2(MAX_CARS+1)-1:0]     CAR_COUNT,
  output logic                              OVERFLOW,
  output logic [1:0]                        STATE
);

  // state    | meaning
  // IDLE     | queue empty
  // WAITING  | cars queued, country road not green
  // DRAINING | cars queued, country road green
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAITING  = 2'd1;
  localparam logic [1:0] DRAINING = 2'd2;

  localparam int CW = $clog2(MAX_CARS + 1);
  localparam logic [1:0] SIG_GREEN = 2'd2;

  logic          sync1;
  logic          sync2;
  logic          deb;
  logic          deb_d;
  logic [7:0]    deb_cnt;
  logic [7:0]    pass_tmr;

  logic          green;
  logic          arrival;
  logic          draining;
  logic          departure;
  logic [CW-1:0] count_next;
  logic          ovf_next;
  logic [1:0]    state_next;

  always_comb begin
    green      = (COUNTRY_SIG == SIG_GREEN);
    arrival    = deb & ~deb_d;
    draining   = green && (CAR_COUNT != '0);
    departure  = draining && (pass_tmr == 8'(PASS_CYCLES - 1));
    count_next = CAR_COUNT;
    ovf_next   = OVERFLOW;
    // Simultaneous arrival and departure cancel out.
    if (arrival && !departure) begin
      if (CAR_COUNT == CW'(MAX_CARS))
        ovf_next = 1'b1;
      else
        count_next = CAR_COUNT + CW'(1);
    end else if (departure && !arrival) begin
      count_next = CAR_COUNT - CW'(1);
    end
    if (count_next == '0)
      state_next = IDLE;
    else if (green)
      state_next = DRAINING;
    else
      state_next = WAITING;
  end

  always_ff @(posedge CLOCK) begin
    if (CLEAR) begin
      sync1               <= 1'b0;
      sync2               <= 1'b0;
      deb                 <= 1'b0;
      deb_d               <= 1'b0;
      deb_cnt             <= 8'd0;
      pass_tmr            <= 8'd0;
      CAR_COUNT           <= '0;
      CAR_ON_COUNTRY_ROAD <= 1'b0;
      OVERFLOW            <= 1'b0;
      STATE               <= IDLE;
    end else begin
      sync1 <= SENSOR_RAW;
      sync2 <= sync1;
      deb_d <= deb;

      if (sync2 == deb) begin
        deb_cnt <= 8'd0;
      end else if (deb_cnt == 8'(DEBOUNCE - 1)) begin
        deb     <= sync2;
        deb_cnt <= 8'd0;
      end else begin
        deb_cnt <= deb_cnt + 8'd1;
      end

      // A partial pass never carries over into the next green phase.
      if (!draining || departure)
        pass_tmr <= 8'd0;
      else
        pass_tmr <= pass_tmr + 8'd1;

      CAR_COUNT           <= count_next;
      CAR_ON_COUNTRY_ROAD <= (count_next != '0);
      OVERFLOW            <= ovf_next;
      STATE               <= state_next;
    end
  end

endmodule
